// File: rtl/display_mode_arbiter.sv
// Display mode arbiter: debounces the mode switches through a settle window,
// commits the new mode only when no key is held, and routes key levels to their owning mode.
module display_mode_arbiter #(
  parameter int SETTLE_CYC = 50
) (
  input  logic       CLK1K,
  input  logic       RSTN,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  input  logic       SW5,
  input  logic       SW6,
  input  logic       KEY_STABLE1,
  input  logic       KEY_STABLE2,
  input  logic       KEY_STABLE3,
  input  logic       TOUCH_KEY1,
  input  logic       TOUCH_KEY2,
  input  logic       TOUCH_KEY3,
  output logic [2:0] MODE,
  output logic [1:0] DISP_SEL,
  output logic [1:0] LED_SEL,
  output logic       SET_KEY1,
  output logic       SET_KEY2,
  output logic       SET_KEY3,
  output logic       STOP_START,
  output logic       MODE_CHG
);

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST   = 8'(SETTLE_CYC - 1);
  localparam logic [2:0] OWNER_NONE = 3'd7;

  logic [5:0]      sw_p0, sw_p1;
  logic [2:0]      rq;
  state_t          state, state_nxt;
  logic [2:0]      cand, cand_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic            commit_now;
  logic [2:0]      key_src, key_prev;
  logic            any_key;
  logic [2:0][2:0] owner, owner_nxt;
  logic [2:0]      set_key_nxt;
  logic            stop_nxt;

  function automatic logic [2:0] decode_rq(input logic [5:0] s);
    if (s[1])             return 3'd2;
    else if (s[5])        return 3'd3;
    else if (s[0] & s[4]) return 3'd5;
    else if (s[0])        return 3'd1;
    else if (s[3])        return 3'd4;
    else                  return 3'd0;
  endfunction

  function automatic logic [1:0] disp_of(input logic [2:0] m);
    case (m)
      3'd2:    return 2'd1;
      3'd3:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] led_of(input logic [2:0] m);
    case (m)
      3'd4:    return 2'd1;
      3'd5:    return 2'd2;
      3'd3:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Stage p0/p1: two-flop switch synchronizer
  always_ff @(posedge CLK1K) begin
    if (!RSTN) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= {SW6, SW5, SW4, SW3, SW2, SW1};
      sw_p1 <= sw_p0;
    end
  end

  assign rq      = decode_rq(sw_p1);
  // Touch keys only act as the key source while the touch-set mode is committed.
  assign key_src = (MODE == 3'd5) ? {TOUCH_KEY3, TOUCH_KEY2, TOUCH_KEY1}
                                  : {KEY_STABLE3, KEY_STABLE2, KEY_STABLE1};
  assign any_key = |key_src;

  always_ff @(posedge CLK1K) begin
    if (!RSTN) begin
      state <= ST_STABLE;
      cand  <= 3'd0;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    case (state)
      ST_STABLE: begin
        if (rq != MODE) begin
          cand_nxt  = rq;
          cnt_nxt   = 8'd0;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (rq == MODE) begin
          state_nxt = ST_STABLE;
        end else if (rq != cand) begin
          cand_nxt = rq;
          cnt_nxt  = 8'd0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = any_key ? ST_WAIT : ST_COMMIT;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_WAIT: begin
        if (rq == MODE) begin
          state_nxt = ST_STABLE;
        end else if (rq != cand) begin
          cand_nxt  = rq;
          cnt_nxt   = 8'd0;
          state_nxt = ST_SETTLE;
        end else if (!any_key) begin
          state_nxt = ST_COMMIT;
        end
      end
      default: state_nxt = ST_STABLE;
    endcase
  end

  // MODE is loaded on the edge that enters COMMIT, so MODE and MODE_CHG share the COMMIT cycle.
  always_comb begin
    commit_now = (state != ST_COMMIT) && (state_nxt == ST_COMMIT);
  end

  always_ff @(posedge CLK1K) begin
    if (!RSTN) begin
      MODE     <= 3'd0;
      MODE_CHG <= 1'b0;
      DISP_SEL <= 2'd0;
      LED_SEL  <= 2'd0;
    end else begin
      MODE     <= commit_now ? cand : MODE;
      MODE_CHG <= commit_now;
      DISP_SEL <= disp_of(MODE);
      LED_SEL  <= led_of(MODE);
    end
  end

  // A key belongs to the mode that was active when it was pressed, until released.
  always_comb begin
    owner_nxt   = owner;
    set_key_nxt = 3'b000;
    for (int n = 0; n < 3; n++) begin
      if (!key_src[n])
        owner_nxt[n] = OWNER_NONE;
      else if (!key_prev[n])
        owner_nxt[n] = MODE;
      set_key_nxt[n] = key_src[n] && ((owner_nxt[n] == 3'd1) || (owner_nxt[n] == 3'd5));
    end
    stop_nxt = key_src[2] && (owner_nxt[2] == 3'd2);
  end

  always_ff @(posedge CLK1K) begin
    if (!RSTN) begin
      key_prev   <= 3'b000;
      owner      <= {OWNER_NONE, OWNER_NONE, OWNER_NONE};
      SET_KEY1   <= 1'b0;
      SET_KEY2   <= 1'b0;
      SET_KEY3   <= 1'b0;
      STOP_START <= 1'b0;
    end else begin
      key_prev   <= key_src;
      owner      <= owner_nxt;
      SET_KEY1   <= set_key_nxt[0];
      SET_KEY2   <= set_key_nxt[1];
      SET_KEY3   <= set_key_nxt[2];
      STOP_START <= stop_nxt;
    end
  end

endmodule

// File: tb/tb_display_mode_arbiter.sv
// Bench for display_mode_arbiter: directed scenarios plus random switch/key traffic,
// every cycle scored against a behavioural model through an expectation queue.
module tb_display_mode_arbiter;

  localparam int SETTLE = 50;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [5:0] sw = '0;
  logic [2:0] ks = '0;
  logic [2:0] tk = '0;
  logic [2:0] mode;
  logic [1:0] disp_sel, led_sel;
  logic       set_key1, set_key2, set_key3, stop_start, mode_chg;

  display_mode_arbiter #(.SETTLE_CYC(SETTLE)) dut (
    .CLK1K(clk), .RSTN(rstn),
    .SW1(sw[0]), .SW2(sw[1]), .SW3(sw[2]), .SW4(sw[3]), .SW5(sw[4]), .SW6(sw[5]),
    .KEY_STABLE1(ks[0]), .KEY_STABLE2(ks[1]), .KEY_STABLE3(ks[2]),
    .TOUCH_KEY1(tk[0]), .TOUCH_KEY2(tk[1]), .TOUCH_KEY3(tk[2]),
    .MODE(mode), .DISP_SEL(disp_sel), .LED_SEL(led_sel),
    .SET_KEY1(set_key1), .SET_KEY2(set_key2), .SET_KEY3(set_key3),
    .STOP_START(stop_start), .MODE_CHG(mode_chg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] mode;
    logic [1:0] disp;
    logic [1:0] led;
    logic [2:0] set_key;
    logic       stop;
    logic       chg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state: mode history with a pending request, its age and a key hold-off
  int   m_mode, m_cand, m_age, m_owner[3];
  bit   m_pending, m_waiting, m_cool;
  bit [5:0] m_sync1, m_sync2;
  bit [2:0] m_prev;
  exp_t m_out;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want)
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    else
      passed++;
  endtask

  function automatic int want_mode(input bit [5:0] s);
    if (s[1]) return 2;
    if (s[5]) return 3;
    if (s[0] && s[4]) return 5;
    if (s[0]) return 1;
    if (s[3]) return 4;
    return 0;
  endfunction

  task automatic model_step();
    bit [2:0] src;
    int rq;
    bit cm;
    if (!rstn) begin
      m_mode = 0; m_cand = 0; m_age = 0;
      m_pending = 0; m_waiting = 0; m_cool = 0;
      m_sync1 = 0; m_sync2 = 0; m_prev = 0;
      for (int n = 0; n < 3; n++) m_owner[n] = -1;
      m_out = '0;
    end else begin
      src = (m_mode == 5) ? tk : ks;
      rq  = want_mode(m_sync2);
      cm  = 0;
      if (m_cool) m_cool = 0;
      else if (!m_pending) begin
        if (rq != m_mode) begin m_pending = 1; m_cand = rq; m_age = 0; m_waiting = 0; end
      end
      else if (rq == m_mode) m_pending = 0;
      else if (rq != m_cand) begin m_cand = rq; m_age = 0; m_waiting = 0; end
      else if (m_waiting) begin if (src == 0) cm = 1; end
      else if (m_age == SETTLE - 1) begin
        if (src != 0) m_waiting = 1; else cm = 1;
      end
      else m_age++;
      for (int n = 0; n < 3; n++) begin
        if (!src[n]) m_owner[n] = -1;
        else if (!m_prev[n]) m_owner[n] = m_mode;
        m_out.set_key[n] = src[n] && (m_owner[n] == 1 || m_owner[n] == 5);
      end
      m_out.stop = src[2] && (m_owner[2] == 2);
      m_out.disp = (m_mode == 2) ? 2'd1 : (m_mode == 3) ? 2'd2 : 2'd0;
      m_out.led  = (m_mode == 4) ? 2'd1 : (m_mode == 5) ? 2'd2 : (m_mode == 3) ? 2'd3 : 2'd0;
      if (cm) begin m_mode = m_cand; m_pending = 0; m_cool = 1; end
      m_out.mode = 3'(m_mode);
      m_out.chg  = cm;
      m_prev  = src;
      m_sync2 = m_sync1;
      m_sync1 = sw;
    end
    sb.push_back(m_out);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; sw = '0; ks = '0; tk = '0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents a full output word; compare with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("cycle_outputs",
              32'({mode, disp_sel, led_sel, set_key3, set_key2, set_key1, stop_start, mode_chg}),
              32'(e));
      end
    end
  end

  initial begin
    do_reset();
    check("reset_outputs",
          32'({mode, disp_sel, led_sel, set_key3, set_key2, set_key1, stop_start, mode_chg}), 0);

    // SW2 rise commits STOP 53 cycles later
    sw[1] = 1'b1;
    repeat (52) tick();
    check("sw2_mode_before", 32'(mode), 0);
    tick();
    check("sw2_mode_53", 32'(mode), 2);
    check("sw2_chg_53", 32'(mode_chg), 1);
    tick();
    check("sw2_disp_54", 32'(disp_sel), 1);
    check("sw2_chg_54", 32'(mode_chg), 0);

    // SW6 then SW2: candidate restarts, TIMER never committed
    do_reset();
    sw[5] = 1'b1;
    repeat (20) tick();
    sw[1] = 1'b1;
    repeat (52) begin
      tick();
      check("restart_never3", 32'(mode == 3'd3), 0);
    end
    tick();
    check("restart_mode_53", 32'(mode), 2);

    // Held key blocks the commit until released
    do_reset();
    sw[0] = 1'b1;
    repeat (53) tick();
    check("set_mode", 32'(mode), 1);
    ks[1] = 1'b1;
    tick();
    check("set_key2_on", 32'(set_key2), 1);
    sw[0] = 1'b0;
    repeat (60) tick();
    check("wait_mode_held", 32'(mode), 1);
    check("wait_key2_held", 32'(set_key2), 1);
    ks[1] = 1'b0;
    tick();
    check("wait_commit_mode", 32'(mode), 0);
    check("wait_commit_chg", 32'(mode_chg), 1);
    check("wait_key2_off", 32'(set_key2), 0);

    // Stopwatch start key
    do_reset();
    sw[1] = 1'b1;
    repeat (53) tick();
    ks[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stop_start_on", 32'(stop_start), 1);
      check("stop_setkey3", 32'(set_key3), 0);
    end
    ks[2] = 1'b0;
    tick();
    check("stop_start_off", 32'(stop_start), 0);

    // TSET mode routes touch keys only
    do_reset();
    sw[0] = 1'b1; sw[4] = 1'b1;
    repeat (53) tick();
    check("tset_mode", 32'(mode), 5);
    tick();
    check("tset_led", 32'(led_sel), 2);
    ks[0] = 1'b1;
    tick();
    check("tset_board_key_ignored", 32'(set_key1), 0);
    ks[0] = 1'b0; tk[0] = 1'b1;
    tick();
    check("tset_touch_key1", 32'(set_key1), 1);
    tk[0] = 1'b0;
    tick();
    check("tset_touch_key1_off", 32'(set_key1), 0);

    // Reset mid-settle discards the candidate
    do_reset();
    sw[1] = 1'b1;
    repeat (20) tick();
    rstn = 1'b0;
    tick();
    check("midreset_outputs",
          32'({mode, disp_sel, led_sel, set_key3, set_key2, set_key1, stop_start, mode_chg}), 0);
    rstn = 1'b1;
    repeat (10) begin
      tick();
      check("midreset_no_chg", 32'(mode_chg), 0);
    end

    // Random traffic
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        int b;
        b = $urandom_range(0, 5);
        sw[b] = ~sw[b];
      end
      for (int k = 0; k < 3; k++) begin
        if (ks[k]) begin if ($urandom_range(0, 7) == 0) ks[k] = 1'b0; end
        else if ($urandom_range(0, 39) == 0) ks[k] = 1'b1;
        if (tk[k]) begin if ($urandom_range(0, 7) == 0) tk[k] = 1'b0; end
        else if ($urandom_range(0, 39) == 0) tk[k] = 1'b1;
      end
      rstn = ($urandom_range(0, 999) != 0);
      tick();
    end

    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
